// File: rtl/robo_pkg.sv
// Shared encodings and orientation helpers for the navigator and the maze map.
package robo_pkg;

  localparam logic [2:0] ORI_N = 3'd1;
  localparam logic [2:0] ORI_W = 3'd2;
  localparam logic [2:0] ORI_E = 3'd3;
  localparam logic [2:0] ORI_S = 3'd4;

  localparam logic [2:0] ACAO_NONE = 3'd0;
  localparam logic [2:0] ACAO_N    = 3'd1;
  localparam logic [2:0] ACAO_W    = 3'd2;
  localparam logic [2:0] ACAO_S    = 3'd3;
  localparam logic [2:0] ACAO_E    = 3'd4;

  localparam logic [7:0] LIN_MAX = 8'd11;
  localparam logic [7:0] COL_MAX = 8'd21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SENSE,
    ST_DONE,
    ST_FAIL
  } estado_t;

  function automatic logic [2:0] esq(input logic [2:0] o);
    case (o)
      ORI_N:   return ORI_W;
      ORI_W:   return ORI_S;
      ORI_S:   return ORI_E;
      ORI_E:   return ORI_N;
      default: return o;
    endcase
  endfunction

  function automatic logic [2:0] dir(input logic [2:0] o);
    case (o)
      ORI_N:   return ORI_E;
      ORI_E:   return ORI_S;
      ORI_S:   return ORI_W;
      ORI_W:   return ORI_N;
      default: return o;
    endcase
  endfunction

  function automatic logic [2:0] acao_frente(input logic [2:0] o);
    case (o)
      ORI_N:   return ACAO_N;
      ORI_W:   return ACAO_W;
      ORI_S:   return ACAO_S;
      ORI_E:   return ACAO_E;
      default: return ACAO_NONE;
    endcase
  endfunction

endpackage

// File: rtl/robo_navegador_if.sv
// Navigator signal bundle: start/status side plus the map sensor/command side.
interface robo_navegador_if;
  logic        start;
  logic        head;
  logic        left;
  logic [2:0]  acao;
  logic [2:0]  orientacao;
  logic        busy;
  logic        done;
  logic        fail;
  logic [15:0] passos;
  logic [7:0]  linha;
  logic [7:0]  coluna;

  modport master (
    input  start, head, left,
    output acao, orientacao, busy, done, fail, passos, linha, coluna
  );

  modport slave (
    output start, head, left,
    input  acao, orientacao, busy, done, fail, passos, linha, coluna
  );
endinterface

// File: rtl/robo_navegador.sv
// Left-hand wall-following controller: one decision every two cycles (ISSUE, SENSE).
module robo_navegador
  import robo_pkg::*;
#(
  parameter int unsigned START_LIN = 11,
  parameter int unsigned START_COL = 1,
  parameter logic [2:0]  START_ORI = 3'b001,
  parameter int unsigned GOAL_LIN  = 0,
  parameter int unsigned GOAL_COL  = 20,
  parameter int unsigned MAX_STEPS = 1000
) (
  input logic              clockc1,
  input logic              reset,
  robo_navegador_if.master nav
);

  estado_t     st_q, st_d;
  logic [2:0]  acao_q, acao_d, ori_q, ori_d;
  logic        busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [15:0] passos_q, passos_d;
  logic [7:0]  lin_q, lin_d, col_q, col_d;
  logic        tl_q, tl_d;
  logic [1:0]  rc_q, rc_d;

  logic        mov_ok;
  logic [7:0]  lin_nx, col_nx;
  logic        fwd, vira_dir, falha;

  // Candidate position for a forward move and whether it stays inside the maze.
  always_comb begin
    mov_ok = 1'b0;
    lin_nx = lin_q;
    col_nx = col_q;
    case (ori_q)
      ORI_N: begin mov_ok = (lin_q != '0);     lin_nx = lin_q - 8'd1; end
      ORI_W: begin mov_ok = (col_q != '0);     col_nx = col_q - 8'd1; end
      ORI_S: begin mov_ok = (lin_q < LIN_MAX); lin_nx = lin_q + 8'd1; end
      ORI_E: begin mov_ok = (col_q < COL_MAX); col_nx = col_q + 8'd1; end
      default: ;
    endcase
  end

  always_comb begin
    st_d     = st_q;
    acao_d   = ACAO_NONE;
    ori_d    = ori_q;
    busy_d   = busy_q;
    done_d   = done_q;
    fail_d   = fail_q;
    passos_d = passos_q;
    lin_d    = lin_q;
    col_d    = col_q;
    tl_d     = tl_q;
    rc_d     = rc_q;
    fwd      = 1'b0;
    vira_dir = 1'b0;
    falha    = 1'b0;

    unique case (st_q)
      ST_IDLE: begin
        if (nav.start) begin
          ori_d  = START_ORI;
          busy_d = 1'b1;
          st_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: st_d = ST_SENSE;
      ST_SENSE: begin
        if (lin_q == 8'(GOAL_LIN) && col_q == 8'(GOAL_COL)) begin
          st_d   = ST_DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (passos_q == 16'(MAX_STEPS)) begin
          falha = 1'b1;
        end else if (tl_q) begin
          // Right after a left turn the left side is the wall just followed.
          tl_d     = 1'b0;
          fwd      = !nav.head;
          vira_dir = nav.head;
        end else if (!nav.left) begin
          ori_d = esq(ori_q);
          tl_d  = 1'b1;
          st_d  = ST_ISSUE;
        end else begin
          fwd      = !nav.head;
          vira_dir = nav.head;
        end

        if (fwd) begin
          if (mov_ok) begin
            acao_d   = acao_frente(ori_q);
            lin_d    = lin_nx;
            col_d    = col_nx;
            passos_d = passos_q + 16'd1;
            rc_d     = '0;
            st_d     = ST_ISSUE;
          end else begin
            falha = 1'b1;
          end
        end

        if (vira_dir) begin
          if (rc_q == 2'd3) begin
            falha = 1'b1;
          end else begin
            ori_d = dir(ori_q);
            rc_d  = rc_q + 2'd1;
            st_d  = ST_ISSUE;
          end
        end
      end
      ST_DONE, ST_FAIL: ;
      default: st_d = ST_IDLE;
    endcase

    if (falha) begin
      st_d   = ST_FAIL;
      busy_d = 1'b0;
      fail_d = 1'b1;
    end
  end

  always_ff @(posedge clockc1 or posedge reset) begin
    if (reset) begin
      st_q     <= ST_IDLE;
      acao_q   <= ACAO_NONE;
      ori_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      passos_q <= '0;
      lin_q    <= 8'(START_LIN);
      col_q    <= 8'(START_COL);
      tl_q     <= 1'b0;
      rc_q     <= '0;
    end else begin
      st_q     <= st_d;
      acao_q   <= acao_d;
      ori_q    <= ori_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      passos_q <= passos_d;
      lin_q    <= lin_d;
      col_q    <= col_d;
      tl_q     <= tl_d;
      rc_q     <= rc_d;
    end
  end

  assign nav.acao       = acao_q;
  assign nav.orientacao = ori_q;
  assign nav.busy       = busy_q;
  assign nav.done       = done_q;
  assign nav.fail       = fail_q;
  assign nav.passos     = passos_q;
  assign nav.linha      = lin_q;
  assign nav.coluna     = col_q;

endmodule
